// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word bundle between uart_rx and its consumer
interface uart_rx_if #(
  parameter int BIT_COUNT = 8
);
  logic [BIT_COUNT-1:0] dout_o;
  logic                 rx_done_tick_o;
  logic                 frame_err_o;

  modport master (output dout_o, rx_done_tick_o, frame_err_o);
  modport slave  (input  dout_o, rx_done_tick_o, frame_err_o);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART receiver with mid-bit sampling and frame-error tick
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int BIT_COUNT  = 8
) (
  input  logic     clk,
  input  logic     rst_i,
  input  logic     rx_i,
  uart_rx_if.master bus
);
  localparam int BIT_TIMER = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_TIMER / 2;
  localparam int TW        = $clog2(BIT_TIMER) + 1;
  localparam int CW        = $clog2(BIT_COUNT) + 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TIMER - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t               state, state_next;
  logic [TW-1:0]        timer, timer_next;
  logic [CW-1:0]        bit_cnt, bit_cnt_next;
  logic [BIT_COUNT-1:0] shift, shift_next;
  logic [BIT_COUNT-1:0] dout_next;
  logic                 done_next, err_next;
  logic                 rx_m, rx_s;

  // Synchronizer flops reset high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state              <= S_IDLE;
      timer              <= '0;
      bit_cnt            <= '0;
      shift              <= '0;
      bus.dout_o         <= '0;
      bus.rx_done_tick_o <= 1'b0;
      bus.frame_err_o    <= 1'b0;
    end else begin
      state              <= state_next;
      timer              <= timer_next;
      bit_cnt            <= bit_cnt_next;
      shift              <= shift_next;
      bus.dout_o         <= dout_next;
      bus.rx_done_tick_o <= done_next;
      bus.frame_err_o    <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer + 1'b1;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    dout_next    = bus.dout_o;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state)
      S_IDLE: begin
        timer_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (timer == HALF_LAST) begin
          timer_next   = '0;
          bit_cnt_next = '0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_next   = '0;
          shift_next   = {rx_s, shift[BIT_COUNT-1:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets the next start bit follow with no gap
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rx_s) begin
            dout_next  = shift;
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        timer_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        timer_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end
endmodule
